// File: rtl/ser_fifo_pkg.sv
// Shared types and helpers for the serial-converter FIFO write arbiter.
// Holds the control FSM encoding, the default word width and the lane-index wrap helper.
package ser_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;

  // Operands are always below 2*num, so one conditional subtract is an exact modulo,
  // also for lane counts that are not a power of two.
  function automatic int unsigned lane_wrap(input int unsigned idx, input int unsigned num);
    return (idx >= num) ? (idx - num) : idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo NUM_REQ.
// Zero latency; gnt_vld stays low while en is low or no request is pending.
module rr_arbiter
  import ser_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  input  logic               en,
  output logic               gnt_vld,
  output logic [TAG_W-1:0]   gnt_idx
);

  logic [TAG_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = TAG_W'(lane_wrap(32'(ptr) + 32'(k), NUM_REQ));
        if (!found && req[idx]) begin
          found   = 1'b1;
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end

endmodule

// File: rtl/ser_fifo_write_arbiter.sv
// Shares one FIFO write port among NUM_REQ converters with one-word holding buffers per lane.
// Capture-to-write latency 2 cycles; fifo_full/fifo_afull stall grants, extra words are dropped into ovf.
module ser_fifo_write_arbiter
  import ser_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [NUM_REQ-1:0]        lane_en,
  output logic [NUM_REQ-1:0]        conv_en,
  input  logic [NUM_REQ-1:0]        conv_wrt,
  input  logic [NUM_REQ*DATA_W-1:0] conv_data,
  input  logic                      fifo_full,
  input  logic                      fifo_afull,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [TAG_W-1:0]          fifo_tag,
  output logic [NUM_REQ-1:0]        ovf,
  input  logic                      ovf_clr,
  output logic                      busy
);

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [NUM_REQ-1:0] hold_vld;
  logic [TAG_W-1:0]   rr_ptr;

  logic               gnt_en;
  logic               gnt_vld;
  logic [TAG_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] cap;
  logic [NUM_REQ-1:0] drop;

  // A write in flight while almost-full could be the one that fills the FIFO, so skip a cycle.
  assign gnt_en = (state != S_IDLE) && !fifo_full && !(fifo_afull && fifo_wr);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_rr (
    .req     (hold_vld),
    .ptr     (rr_ptr),
    .en      (gnt_en),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  // A lane being drained this edge can take a new word in the same edge.
  assign cap  = conv_wrt & (~hold_vld | gnt_oh);
  assign drop = conv_wrt & hold_vld & ~gnt_oh;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (run) state_nxt = S_RUN;
      S_RUN:   if (!run) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (run)
          state_nxt = S_RUN;
        else if ((hold_vld == '0) && !fifo_wr)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      hold_vld <= '0;
      ovf      <= '0;
      rr_ptr   <= '0;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
      fifo_tag <= '0;
    end else begin
      state    <= state_nxt;
      hold_vld <= (hold_vld & ~gnt_oh) | cap;
      ovf      <= drop | (ovf & ~{NUM_REQ{ovf_clr}});
      fifo_wr  <= gnt_vld;
      if (gnt_vld) begin
        fifo_din <= hold_data[gnt_idx];
        fifo_tag <= gnt_idx;
        rr_ptr   <= TAG_W'(lane_wrap(32'(gnt_idx) + 32'd1, NUM_REQ));
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst)
        hold_data[i] <= '0;
      else if (cap[i])
        hold_data[i] <= conv_data[i*DATA_W +: DATA_W];
    end
  end

  assign conv_en = (state == S_RUN) ? (lane_en & ~hold_vld) : '0;
  assign busy    = (state != S_IDLE);

endmodule

// File: doc/ser_fifo_write_arbiter.md
# ser_fifo_write_arbiter

Shares the single write port of the FIFO between NUM_REQ serial-to-parallel converters. It gates each converter's enable, buffers one completed word per lane, and grants the FIFO write port round-robin under full/almost-full backpressure. It tags each write with its source lane and flags dropped words. It sits between the converter bank and the FIFO write side.

## Interface
Parameters:
- NUM_REQ, 4, number of converter lanes (2..8).
- DATA_W, 32, word width; must match the converter output width.
- TAG_W, $clog2(NUM_REQ), lane tag width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- run  in  1  host start/stop request.
- lane_en  in  NUM_REQ  per-lane host enable.
- conv_en  out  NUM_REQ  enable to each converter.
- conv_wrt  in  NUM_REQ  one-cycle word-complete strobe from each converter.
- conv_data  in  NUM_REQ*DATA_W  lane i word at [i*DATA_W +: DATA_W].
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- fifo_afull  in  1  FIFO has at most one free entry.
- fifo_wr  out  1  registered write strobe.
- fifo_din  out  DATA_W  registered write data.
- fifo_tag  out  TAG_W  lane index of fifo_din.
- ovf  out  NUM_REQ  sticky per-lane overflow (word dropped).
- ovf_clr  in  1  clears all ovf bits.
- busy  out  1  high in S_RUN and S_DRAIN.

## Operation
- FSM states and transitions:
  - S_IDLE → S_RUN when run=1.
  - S_RUN → S_DRAIN when run=0.
  - S_DRAIN → S_IDLE when no hold_vld bit is set and fifo_wr=0.
  - S_DRAIN → S_RUN when run=1 is seen in S_DRAIN.
- conv_en[i] = (state==S_RUN) & lane_en[i] & ~hold_vld[i]. It is a combinational decode of registers only.
- Holding register per lane: hold_data[i] and hold_vld[i].
- Capture: conv_wrt[i]=1 at an edge loads hold_data[i] and sets hold_vld[i] if hold_vld[i]=0, or if lane i is granted at that same edge.
- Drop: conv_wrt[i]=1 with hold_vld[i]=1 and lane i not granted discards the word and sets ovf[i]. Capture is active in all states, including S_IDLE.
- Grant is evaluated each cycle when state≠S_IDLE.
  - Grant condition: any hold_vld set, fifo_full=0, and not (fifo_afull=1 and fifo_wr=1).
  - The winner is the first set hold_vld bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
- On grant at edge t:
  - fifo_din ← hold_data[w], fifo_tag ← w, fifo_wr ← 1 for one cycle.
  - hold_vld[w] clears, unless recaptured at the same edge.
  - rr_ptr ← (w+1) mod NUM_REQ; the wrap is explicit, never a truncating add for non-power-of-2 NUM_REQ.
- No grant: fifo_wr ← 0. fifo_din and fifo_tag hold their last values. rr_ptr is unchanged.
- ovf_clr clears all ovf bits. A new drop in the same cycle wins, so that bit stays set.

## Timing
- Reset (rst=0 at an edge) gives:
  - state S_IDLE, rr_ptr 0, hold_vld 0, ovf 0.
  - fifo_wr 0, fifo_din 0, fifo_tag 0.
  - conv_en 0, busy 0.
- Reset mid-operation discards held words without writing them.
- Latency from conv_wrt high at edge N, with the lane free and the FIFO not full:
  - hold_vld is high after edge N.
  - The grant is evaluated in cycle N+1.
  - fifo_wr is high in cycle N+2.
- conv_en[i] falls in the cycle after capture and rises in the cycle after the grant that clears hold_vld[i].
- Throughput: one FIFO write per cycle aggregate, and at most one write per cycle.
- Fairness: with every lane continuously valid, each lane is granted exactly once per NUM_REQ consecutive grants.
- fifo_afull guard: back-to-back writes stop when fifo_afull=1, so the FIFO is never written while full.
- busy tracks state directly: it rises the cycle after run rises and falls the cycle after the drain completes.

## Structure
- Package ser_fifo_pkg holds:
  - the state enum (S_IDLE, S_RUN, S_DRAIN);
  - the default DATA_W=32;
  - a lane-index function for the modulo wrap.
- Sub-module rr_arbiter (parameter NUM_REQ): inputs req vector, ptr, and enable; outputs gnt_vld and gnt_idx. It is purely combinational.
- The top module holds the FSM, the holding registers, the output registers, rr_ptr, and ovf.

## Test plan
- Reset: drive rst=0 for 2 cycles while run=1 and conv_wrt=all-ones. Outputs must be 0, ovf 0, and state S_IDLE afterwards.
- Single word: in S_RUN, drive conv_wrt[2] with data 0xDEADBEEF at edge N. Required: fifo_wr=1 in cycle N+2, fifo_din=0xDEADBEEF, fifo_tag=2, and conv_en[2] low in cycle N+1 only.
- Round-robin (NUM_REQ=4): load all four lanes in the same cycle. Required: grants in tag order 0,1,2,3 on consecutive cycles. Then reload lanes 1 and 3 only; required grants 1 then 3.
- Backpressure and overflow:
  - Hold fifo_full=1 and fill lane 0, then pulse conv_wrt[0] again. Required: ovf[0]=1 and the first word is retained.
  - Release fifo_full. Required: exactly one write of the first word.
  - Pulse ovf_clr together with a new drop. Required: ovf[0] stays 1.
- afull guard: set fifo_afull=1 with 3 lanes valid. Required: no two consecutive fifo_wr cycles.
- Drain: deassert run with 3 words held. Required: conv_en=0 immediately, 3 writes issued, then busy=0 and state S_IDLE.
